// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB sequencer, GPR file,
// ALU and a single req/ack memory port shared by instruction fetch and load/store.
module mc_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] Dout,
  output logic [31:0] pc_out,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] dout_q, dout_d;
  logic        illegal_q, illegal_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm, rs_val, rt_val;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  // R0 and indices beyond NREGS read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (rs == i[4:0]) rs_val = rf_q[i];
      if (rt == i[4:0]) rt_val = rf_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    mdr_d     = mdr_q;
    dout_d    = dout_q;
    illegal_d = illegal_q;
    wr_en     = 1'b0;
    wr_idx    = rt;
    wr_data   = dout_q;

    case (state_q)
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = rs_val;
        b_d     = rt_val;
        dout_d  = pc_q + {sext_imm[29:0], 2'b00};
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        case (op)
          OpRtype: begin
            state_d = StWb;
            case (funct)
              FnAdd:   dout_d = a_q + b_q;
              FnSub:   dout_d = a_q - b_q;
              FnAnd:   dout_d = a_q & b_q;
              FnOr:    dout_d = a_q | b_q;
              FnSlt:   dout_d = {31'd0, $signed(a_q) < $signed(b_q)};
              default: begin
                illegal_d = 1'b1;
                state_d   = StFetch;
              end
            endcase
          end
          OpAddi: begin
            dout_d  = a_q + sext_imm;
            state_d = StWb;
          end
          OpLw, OpSw: begin
            dout_d  = a_q + sext_imm;
            state_d = StMem;
          end
          OpBeq:   if (a_q == b_q) pc_d = dout_q;
          OpBne:   if (a_q != b_q) pc_d = dout_q;
          default: illegal_d = 1'b1;
        endcase
      end
      StMem: begin
        if (mem_ack) begin
          if (op == OpLw) begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        wr_en   = 1'b1;
        wr_idx  = (op == OpRtype) ? rd : rt;
        wr_data = (op == OpLw) ? mdr_q : dout_q;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (wr_en && wr_idx == i[4:0]) rf_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdr_q     <= '0;
      dout_q    <= '0;
      illegal_q <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mdr_q     <= mdr_d;
      dout_q    <= dout_d;
      illegal_q <= illegal_d;
      rf_q      <= rf_d;
    end
  end

  // Request is gated by reset so the bus goes quiet the instant reset rises.
  assign mem_req   = ~reset & ((state_q == StFetch) | (state_q == StMem));
  assign mem_we    = ~reset & (state_q == StMem) & (op == OpSw);
  assign mem_addr  = (state_q == StMem) ? dout_q : pc_q;
  assign mem_wdata = b_q;
  assign Dout      = dout_q;
  assign pc_out    = pc_q;
  assign state     = state_q;
  assign illegal   = illegal_q;

endmodule
